// File: rtl/io_pkg.sv
// Shared constants for io_ctrl: register offsets, event-control layout, seven-segment table.
package io_pkg;

    localparam int unsigned NSW  = 10;
    localparam int unsigned NKEY = 4;
    localparam int unsigned NIN  = NSW + NKEY;

    localparam logic [7:0] OFS_HEX   = 8'h00;
    localparam logic [7:0] OFS_LEDR  = 8'h04;
    localparam logic [7:0] OFS_LEDG  = 8'h08;
    localparam logic [7:0] OFS_KDATA = 8'h10;
    localparam logic [7:0] OFS_KCTRL = 8'h14;
    localparam logic [7:0] OFS_SDATA = 8'h18;
    localparam logic [7:0] OFS_TCNT  = 8'h20;
    localparam logic [7:0] OFS_TLIM  = 8'h24;
    localparam logic [7:0] OFS_TCTRL = 8'h28;

    localparam int unsigned CTRL_READY   = 0;
    localparam int unsigned CTRL_OVERRUN = 1;

    // Layout matches CTRL_READY/CTRL_OVERRUN bit positions when zero-extended.
    typedef struct packed {
        logic overrun;
        logic ready;
    } evt_ctrl_t;

    // Active-low segments, bit 0 = segment a ... bit 6 = segment g.
    function automatic logic [6:0] seg_lut(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Ready/overrun update; an event in the same cycle as a clear leaves ready=1, overrun=0.
    function automatic evt_ctrl_t evt_next(input evt_ctrl_t cur, input logic evt, input logic clr);
        evt_ctrl_t nxt;
        nxt = cur;
        if (evt) begin
            nxt.ready   = 1'b1;
            nxt.overrun = clr ? 1'b0 : (cur.overrun | cur.ready);
        end else if (clr) begin
            nxt = '0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/io_if.sv
// Processor data-memory port as seen by the I/O window.
interface io_if #(
    parameter int unsigned DBITS = 32
);
    logic [DBITS-1:0] addr;
    logic [DBITS-1:0] wdata;
    logic             we;
    logic [DBITS-1:0] rdata;
    logic             hit;

    modport master (output addr, output wdata, output we, input rdata, input hit);
    modport slave  (input addr, input wdata, input we, output rdata, output hit);
endinterface

// File: rtl/seven_seg.sv
// Nibble to active-low seven-segment decoder.
module seven_seg
    import io_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);
    assign seg_c = seg_lut(nibble);
endmodule

// File: rtl/io_ctrl.sv
// Memory-mapped board I/O: HEX/LED registers, debounced SW/KEY, key events, ms timer.
// The timer and its registers exist only when IO_TIMER_EN is defined.
module io_ctrl
    import io_pkg::*;
#(
    parameter int unsigned      DBITS           = 32,
    parameter logic [DBITS-1:0] IO_BASE         = 32'hF000_0000,
    parameter int unsigned      DEBOUNCE_CYCLES = 500000,
    parameter int unsigned      TIMER_TICK      = 50000
) (
    input  logic       clk,
    input  logic       reset,
    io_if.slave        bus,
    input  logic [9:0] sw,
    input  logic [3:0] key,
    output logic [9:0] ledr,
    output logic [7:0] ledg,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [7:0]       ofs;
    logic             wr;
    logic [15:0]      hex_q;
    evt_ctrl_t        kctrl;
    logic [NIN-1:0]   raw, sync1, sync2, stable, upd;
    logic             key_evt;
    logic [DBITS-1:0] rdata_c;

    assign ofs     = bus.addr[7:0];
    assign bus.hit = (bus.addr[DBITS-1:8] == IO_BASE[DBITS-1:8]);
    assign wr      = bus.we && bus.hit;

    // Keys are inverted up front so every input bit reads 1 = active.
    assign raw = {~key, sw};

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NIN; i++) begin : g_db
        logic [DB_W-1:0] cnt;
        logic            stb;

        assign upd[i]    = (sync2[i] != stb) && (cnt == DB_W'(DEBOUNCE_CYCLES - 1));
        assign stable[i] = stb;

        always_ff @(posedge clk) begin
            if (!reset) begin
                cnt <= '0;
                stb <= 1'b0;
            end else if (sync2[i] == stb) begin
                cnt <= '0;
            end else if (upd[i]) begin
                cnt <= '0;
                stb <= sync2[i];
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end
    end

    assign key_evt = |(upd[NIN-1:NSW] & sync2[NIN-1:NSW]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            hex_q <= '0;
            ledr  <= '0;
            ledg  <= '0;
            kctrl <= '0;
        end else begin
            if (wr && ofs == OFS_HEX)  hex_q <= bus.wdata[15:0];
            if (wr && ofs == OFS_LEDR) ledr  <= bus.wdata[9:0];
            if (wr && ofs == OFS_LEDG) ledg  <= bus.wdata[7:0];
            kctrl <= evt_next(kctrl, key_evt, wr && ofs == OFS_KCTRL);
        end
    end

`ifdef IO_TIMER_EN
    localparam int unsigned PS_W = (TIMER_TICK > 1) ? $clog2(TIMER_TICK) : 1;

    logic [PS_W-1:0]  presc;
    logic [DBITS-1:0] tcnt, tlim;
    evt_ctrl_t        tctrl;
    logic             tick, twrap, wr_tcnt;

    assign wr_tcnt = wr && ofs == OFS_TCNT;
    assign tick    = (presc == PS_W'(TIMER_TICK - 1));
    assign twrap   = tick && (tlim != '0) && (tcnt == tlim - DBITS'(1));

    // A TCNT store beats a same-cycle increment and restarts the prescaler.
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc <= '0;
            tcnt  <= '0;
            tlim  <= '0;
            tctrl <= '0;
        end else begin
            if (wr_tcnt) begin
                tcnt  <= bus.wdata;
                presc <= '0;
            end else if (tick) begin
                presc <= '0;
                tcnt  <= twrap ? '0 : tcnt + DBITS'(1);
            end else begin
                presc <= presc + PS_W'(1);
            end
            if (wr && ofs == OFS_TLIM) tlim <= bus.wdata;
            tctrl <= evt_next(tctrl, twrap && !wr_tcnt, wr && ofs == OFS_TCTRL);
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{bus.wdata[DBITS-1:16], 32'(TIMER_TICK)};
`endif

    // Combinational read so a single-cycle load completes in its issuing cycle.
    always_comb begin
        rdata_c = '0;
        if (bus.hit) begin
            case (ofs)
                OFS_HEX:   rdata_c = DBITS'(hex_q);
                OFS_LEDR:  rdata_c = DBITS'(ledr);
                OFS_LEDG:  rdata_c = DBITS'(ledg);
                OFS_KDATA: rdata_c = DBITS'(stable[NIN-1:NSW]);
                OFS_KCTRL: rdata_c = DBITS'(kctrl);
                OFS_SDATA: rdata_c = DBITS'(stable[NSW-1:0]);
`ifdef IO_TIMER_EN
                OFS_TCNT:  rdata_c = tcnt;
                OFS_TLIM:  rdata_c = tlim;
                OFS_TCTRL: rdata_c = DBITS'(tctrl);
`endif
                default:   rdata_c = '0;
            endcase
        end
    end

    assign bus.rdata = rdata_c;

    seven_seg u_hex0 (.nibble(hex_q[3:0]),   .seg_c(hex0));
    seven_seg u_hex1 (.nibble(hex_q[7:4]),   .seg_c(hex1));
    seven_seg u_hex2 (.nibble(hex_q[11:8]),  .seg_c(hex2));
    seven_seg u_hex3 (.nibble(hex_q[15:12]), .seg_c(hex3));

endmodule

// File: tb/tb_io_ctrl.sv
// Self-checking bench for io_ctrl with a window-based debounce/event reference model.
module tb_io_ctrl;

    localparam int unsigned DB   = 4;
    localparam int unsigned TICK = 2;
    localparam logic [31:0] BASE = 32'hF000_0000;
`ifdef IO_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    localparam logic [7:0] O_HEX = 8'h00, O_LEDR = 8'h04, O_LEDG = 8'h08, O_GAP = 8'h0C;
    localparam logic [7:0] O_KDATA = 8'h10, O_KCTRL = 8'h14, O_SDATA = 8'h18;
    localparam logic [7:0] O_TCNT = 8'h20, O_TLIM = 8'h24, O_TCTRL = 8'h28;

    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] sw;
    logic [3:0] key;
    logic [9:0] ledr;
    logic [7:0] ledg;
    logic [6:0] hex0, hex1, hex2, hex3;

    int n_checks = 0;
    int n_fail   = 0;

    io_if #(.DBITS(32)) bus ();

    io_ctrl #(
        .DBITS(32), .IO_BASE(BASE), .DEBOUNCE_CYCLES(DB), .TIMER_TICK(TICK)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .sw(sw), .key(key), .ledr(ledr), .ledg(ledg),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3)
    );

    always #5 clk = ~clk;

    // Reference: an input bit flips once its last DB synchronized samples all disagree with it.
    logic [13:0] hist [0:DB];
    logic [13:0] m_stable;
    logic [13:0] m_upd;
    logic [1:0]  m_kctrl;
    logic        m_kev, m_clr;

    always_comb begin
        m_upd = '1;
        for (int j = 1; j <= DB; j++) m_upd = m_upd & (hist[j] ^ m_stable);
        m_kev = |(m_upd[13:10] & ~m_stable[13:10]);
        m_clr = bus.we && (bus.addr == (BASE | 32'(O_KCTRL)));
    end

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i <= DB; i++) hist[i] <= '0;
            m_stable <= '0;
            m_kctrl  <= '0;
        end else begin
            for (int i = DB; i > 0; i--) hist[i] <= hist[i-1];
            hist[0]  <= {~key, sw};
            m_stable <= m_stable ^ m_upd;
            if (m_kev)      m_kctrl <= m_clr ? 2'b01 : {m_kctrl[1] | m_kctrl[0], 1'b1};
            else if (m_clr) m_kctrl <= 2'b00;
        end
    end

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic bus_write(input logic [7:0] ofs, input logic [31:0] d);
        bus.addr = BASE | 32'(ofs); bus.wdata = d; bus.we = 1'b1;
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] ofs, output logic [31:0] d);
        bus.we = 1'b0; bus.addr = BASE | 32'(ofs);
        #1 d = bus.rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b0; key = 4'hF; sw = '0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bus_read(O_TCNT, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_tcnt got %h want 0", d); end
        bus_read(O_HEX, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_hex got %h want 0", d); end
        bus_read(O_LEDR, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ledr_reg got %h want 0", d); end
        bus_read(O_KCTRL, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_kctrl got %h want 0", d); end
        n_checks++;
        if ({hex3, hex2, hex1, hex0} !== {4{7'h40}}) begin
            n_fail++; $display("FAIL reset_segs got %h %h %h %h want 40 each", hex3, hex2, hex1, hex0);
        end
        n_checks++;
        if (ledr !== 10'h0 || ledg !== 8'h0) begin
            n_fail++; $display("FAIL reset_leds got %h %h want 0 0", ledr, ledg);
        end
        bus.addr = 32'h0000_0010; #1;
        n_checks++; if (bus.hit !== 1'b0) begin n_fail++; $display("FAIL hit_outside got %b want 0", bus.hit); end
        bus.addr = BASE | 32'h10; #1;
        n_checks++; if (bus.hit !== 1'b1) begin n_fail++; $display("FAIL hit_inside got %b want 1", bus.hit); end
        @(negedge clk);
    endtask

    task automatic test_hex_leds();
        logic [31:0] d, v;
        for (int r = 0; r < 3; r++) begin
            v = (r == 0) ? 32'h0000_BEEF : $urandom;
            bus_write(O_HEX, v);
            n_checks++;
            if ({hex3, hex2, hex1, hex0} !== {SEG[v[15:12]], SEG[v[11:8]], SEG[v[7:4]], SEG[v[3:0]]}) begin
                n_fail++; $display("FAIL hex_segs data %h got %h %h %h %h", v, hex3, hex2, hex1, hex0);
            end
            bus_read(O_HEX, d);
            n_checks++; if (d !== {16'h0, v[15:0]}) begin n_fail++; $display("FAIL hex_read got %h want %h", d, v[15:0]); end
            v = (r == 0) ? 32'h0000_03FF : $urandom;
            bus_write(O_LEDR, v);
            n_checks++; if (ledr !== v[9:0]) begin n_fail++; $display("FAIL ledr got %h want %h", ledr, v[9:0]); end
            bus_read(O_LEDR, d);
            n_checks++; if (d !== {22'h0, v[9:0]}) begin n_fail++; $display("FAIL ledr_read got %h want %h", d, v[9:0]); end
            v = $urandom;
            bus_write(O_LEDG, v);
            bus_read(O_LEDG, d);
            n_checks++;
            if (ledg !== v[7:0] || d !== {24'h0, v[7:0]}) begin
                n_fail++; $display("FAIL ledg got %h read %h want %h", ledg, d, v[7:0]);
            end
        end
        bus_write(O_GAP, 32'hFFFF_FFFF);
        bus_read(O_GAP, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read got %h want 0", d); end
    endtask

    task automatic test_keys();
        logic [31:0] d;
        int k, k2;
        k = $urandom_range(0, 3);
        key[k] = 1'b0;
        repeat (2) @(negedge clk);
        key = 4'hF;
        repeat (8) @(negedge clk);
        bus_read(O_KDATA, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_kdata got %h want 0", d); end
        bus_read(O_KCTRL, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_kctrl got %h want 0", d); end

        key[k] = 1'b0;
        repeat (5) @(negedge clk);
        bus_read(O_KDATA, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL press_early got %h want 0", d); end
        @(negedge clk);
        bus_read(O_KDATA, d);
        n_checks++; if (d !== 32'(1 << k)) begin n_fail++; $display("FAIL press_kdata got %h want %h", d, 32'(1 << k)); end
        bus_read(O_KCTRL, d);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL press_kctrl got %h want 1", d); end

        key = 4'hF;
        repeat (8) @(negedge clk);
        k2 = $urandom_range(0, 3);
        key[k2] = 1'b0;
        repeat (8) @(negedge clk);
        bus_read(O_KCTRL, d);
        n_checks++; if (d !== 32'h3) begin n_fail++; $display("FAIL overrun_kctrl got %h want 3", d); end
    endtask

    task automatic test_clear_race();
        logic [31:0] d;
        bit found;
        key = 4'hF;
        repeat (8) @(negedge clk);
        bus_write(O_KCTRL, 32'h0);
        bus_read(O_KCTRL, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL kctrl_clear got %h want 0", d); end
        key[$urandom_range(0, 3)] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (m_kev) found = 1'b1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL race_timeout got no press want press within 20"); end
        bus_write(O_KCTRL, 32'hFFFF_FFFF);
        bus_read(O_KCTRL, d);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL race_kctrl got %h want 1", d); end
        key = 4'hF;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_switches();
        logic [31:0] d;
        logic [9:0]  s2;
        sw = 10'h2A5;
        repeat (5) @(negedge clk);
        bus_read(O_SDATA, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL sw_early got %h want 0", d); end
        @(negedge clk);
        bus_read(O_SDATA, d);
        n_checks++; if (d !== 32'h2A5) begin n_fail++; $display("FAIL sw_settle got %h want 2a5", d); end

        s2 = 10'($urandom_range(1, 1023));
        sw = s2;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        bus_read(O_SDATA, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL sw_reset got %h want 0", d); end
        bus_read(O_KCTRL, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL kctrl_reset got %h want 0", d); end
        repeat (5) @(negedge clk);
        bus_read(O_SDATA, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL sw_redb_early got %h want 0", d); end
        @(negedge clk);
        bus_read(O_SDATA, d);
        n_checks++; if (d !== 32'(s2)) begin n_fail++; $display("FAIL sw_redb got %h want %h", d, s2); end
    endtask

    task automatic test_timer();
        logic [31:0] d, e;
        int m;
        bus_write(O_TLIM, 32'd3);
        bus_write(O_TCTRL, 32'h0);
        bus_write(O_TCNT, 32'h0);
        bus_read(O_TLIM, d);
        e = TIMER_EN ? 32'd3 : 32'd0;
        n_checks++; if (d !== e) begin n_fail++; $display("FAIL tlim_read got %h want %h", d, e); end
        // c counts edges since the TCNT store; one increment per TICK edges
        for (int c = 0; c <= 13; c++) begin
            if (c > 0) @(negedge clk);
            m = c / TICK;
            bus_read(O_TCNT, d);
            e = TIMER_EN ? 32'(m % 3) : 32'd0;
            n_checks++; if (d !== e) begin n_fail++; $display("FAIL tcnt c=%0d got %h want %h", c, d, e); end
            bus_read(O_TCTRL, d);
            e = !TIMER_EN ? 32'd0 : (m / 3 == 0) ? 32'd0 : (m / 3 == 1) ? 32'd1 : 32'd3;
            n_checks++; if (d !== e) begin n_fail++; $display("FAIL tctrl c=%0d got %h want %h", c, d, e); end
        end
        bus_write(O_TCNT, 32'd100);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            bus_read(O_TCNT, d);
            e = !TIMER_EN ? 32'd0 : (c < 2) ? 32'd100 : 32'd101;
            n_checks++; if (d !== e) begin n_fail++; $display("FAIL tcnt_collide c=%0d got %h want %h", c, d, e); end
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        int hold_k = 0, hold_s = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            bus.we = 1'b0;
            bus_read(O_KDATA, d);
            n_checks++; if (d !== 32'(m_stable[13:10])) begin n_fail++; $display("FAIL rnd_kdata c=%0d got %h want %h", c, d, m_stable[13:10]); end
            bus_read(O_SDATA, d);
            n_checks++; if (d !== 32'(m_stable[9:0])) begin n_fail++; $display("FAIL rnd_sdata c=%0d got %h want %h", c, d, m_stable[9:0]); end
            bus_read(O_KCTRL, d);
            n_checks++; if (d !== 32'(m_kctrl)) begin n_fail++; $display("FAIL rnd_kctrl c=%0d got %h want %h", c, d, m_kctrl); end
            if (hold_k == 0) begin key = 4'($urandom); hold_k = $urandom_range(1, 8); end else hold_k--;
            if (hold_s == 0) begin sw = 10'($urandom); hold_s = $urandom_range(1, 8); end else hold_s--;
            if ($urandom_range(0, 9) == 0) begin
                bus.addr = BASE | 32'(O_KCTRL); bus.wdata = $urandom; bus.we = 1'b1;
            end
        end
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hex_leds();
        test_keys();
        test_clear_race();
        test_switches();
        test_timer();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
